// File: rtl/aes_sbox_scheduler_if.sv
// Bundle of request, PRNG, sbox and response signals for the shared-sbox scheduler.
interface aes_sbox_scheduler_if #(
    parameter int SHARES = 2,
    parameter int TAGW   = 4
);
    logic                  ClearxSI;
    logic                  ReqAValidxSI;
    logic                  ReqAReadyxSO;
    logic [8*SHARES-1:0]   ReqADataxDI;
    logic [TAGW-1:0]       ReqATagxDI;
    logic                  ReqBValidxSI;
    logic                  ReqBReadyxSO;
    logic [8*SHARES-1:0]   ReqBDataxDI;
    logic [TAGW-1:0]       ReqBTagxDI;
    logic                  RndValidxSI;
    logic                  RndReqxSO;
    logic [8*SHARES-1:0]   SboxInxDO;
    logic [8*SHARES-1:0]   SboxOutxDI;
    logic                  RspAValidxSO;
    logic                  RspBValidxSO;
    logic [8*SHARES-1:0]   RspDataxDO;
    logic [TAGW-1:0]       RspTagxDO;
    logic                  BusyxSO;

    // Scheduler side
    modport slave (
        input  ClearxSI, ReqAValidxSI, ReqADataxDI, ReqATagxDI,
        input  ReqBValidxSI, ReqBDataxDI, ReqBTagxDI,
        input  RndValidxSI, SboxOutxDI,
        output ReqAReadyxSO, ReqBReadyxSO, RndReqxSO, SboxInxDO,
        output RspAValidxSO, RspBValidxSO, RspDataxDO, RspTagxDO, BusyxSO
    );

    // Requester / PRNG / sbox side
    modport master (
        output ClearxSI, ReqAValidxSI, ReqADataxDI, ReqATagxDI,
        output ReqBValidxSI, ReqBDataxDI, ReqBTagxDI,
        output RndValidxSI, SboxOutxDI,
        input  ReqAReadyxSO, ReqBReadyxSO, RndReqxSO, SboxInxDO,
        input  RspAValidxSO, RspBValidxSO, RspDataxDO, RspTagxDO, BusyxSO
    );
endinterface

// File: rtl/aes_sbox_scheduler.sv
// Shares one masked pipelined sbox between the state datapath (A) and the
// key schedule (B). Round-robin, mask-gated issue; a tracking shift register
// steers each result back to its requester a fixed LATENCY+1 edges after accept.
module aes_sbox_scheduler #(
    parameter int SHARES  = 2,
    parameter int LATENCY = 5,
    parameter int TAGW    = 4
) (
    input logic                 ClkxCI,
    input logic                 RstxRI,
    aes_sbox_scheduler_if.slave bus
);
    localparam int DW = 8 * SHARES;

    typedef struct packed {
        logic            valid;
        logic            src;     // 0 = A, 1 = B
        logic [TAGW-1:0] tag;
    } trk_t;

    logic            ptr_q, ptr_d;          // 0 = A has priority
    logic [DW-1:0]   sbox_in_q, sbox_in_d;
    trk_t            trk_q [LATENCY+1];
    trk_t            trk_d [LATENCY+1];
    logic            rsp_a_q, rsp_a_d;
    logic            rsp_b_q, rsp_b_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
    logic            issue_ok, grant_a, grant_b, ready_a, ready_b, busy;

    // Round-robin grant, qualified by fresh mask and no flush
    always_comb begin
        issue_ok = bus.RndValidxSI & ~bus.ClearxSI;
        grant_a  = bus.ReqAValidxSI & (~bus.ReqBValidxSI | ~ptr_q);
        grant_b  = bus.ReqBValidxSI & (~bus.ReqAValidxSI |  ptr_q);
        ready_a  = grant_a & issue_ok;
        ready_b  = grant_b & issue_ok;
    end

    // Next pointer, held sbox input (no share transitions on stall) and tracking shift
    always_comb begin
        ptr_d     = ptr_q;
        sbox_in_d = sbox_in_q;
        if (ready_a) begin
            ptr_d     = 1'b1;
            sbox_in_d = bus.ReqADataxDI;
        end else if (ready_b) begin
            ptr_d     = 1'b0;
            sbox_in_d = bus.ReqBDataxDI;
        end
        trk_d[0].valid = ready_a | ready_b;
        trk_d[0].src   = ready_b;
        trk_d[0].tag   = ready_b ? bus.ReqBTagxDI : bus.ReqATagxDI;
        for (int i = 1; i <= LATENCY; i++) begin
            trk_d[i] = trk_q[i-1];
        end
        if (bus.ClearxSI) begin
            for (int i = 0; i <= LATENCY; i++) begin
                trk_d[i].valid = 1'b0;
            end
        end
    end

    // Response capture from the last tracking stage; a flush cannot stop it
    always_comb begin
        rsp_a_d    = trk_q[LATENCY].valid & ~trk_q[LATENCY].src;
        rsp_b_d    = trk_q[LATENCY].valid &  trk_q[LATENCY].src;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        if (trk_q[LATENCY].valid) begin
            rsp_data_d = bus.SboxOutxDI;
            rsp_tag_d  = trk_q[LATENCY].tag;
        end
    end

    // Busy whenever any tracking stage holds a byte
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            busy = busy | trk_q[i].valid;
        end
    end

    // State registers
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            ptr_q      <= 1'b0;
            sbox_in_q  <= '0;
            rsp_a_q    <= 1'b0;
            rsp_b_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            sbox_in_q  <= sbox_in_d;
            rsp_a_q    <= rsp_a_d;
            rsp_b_q    <= rsp_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            for (int i = 0; i <= LATENCY; i++) begin
                trk_q[i] <= trk_d[i];
            end
        end
    end

    assign bus.ReqAReadyxSO = ready_a;
    assign bus.ReqBReadyxSO = ready_b;
    assign bus.RndReqxSO    = ready_a | ready_b;
    assign bus.SboxInxDO    = sbox_in_q;
    assign bus.RspAValidxSO = rsp_a_q;
    assign bus.RspBValidxSO = rsp_b_q;
    assign bus.RspDataxDO   = rsp_data_q;
    assign bus.RspTagxDO    = rsp_tag_q;
    assign bus.BusyxSO      = busy;
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// Bench for aes_sbox_scheduler: a 2-share sbox model with LAT-edge latency,
// a queue-based reference of accepted bytes checked every negedge, and
// directed scenarios with hand-computed literals.
module tb_aes_sbox_scheduler;
    localparam int LAT = 5;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    aes_sbox_scheduler_if #(.SHARES(2), .TAGW(4)) bus ();

    aes_sbox_scheduler #(.SHARES(2), .LATENCY(LAT), .TAGW(4)) dut (
        .ClkxCI (clk),
        .RstxRI (rst),
        .bus    (bus)
    );

    logic [7:0] sbox_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Masked sbox behaviour: output shares {m, S(x)^m} with a mask derived from the input
    function automatic logic [15:0] sbox_f(input logic [15:0] x);
        logic [7:0] m;
        m = x[7:0] ^ 8'h3C;
        return {m, sbox_tab[x[7:0] ^ x[15:8]] ^ m};
    endfunction

    // Shared request byte with value v, share0 at [7:0]
    function automatic logic [15:0] mk(input logic [7:0] v, input logic [3:0] t);
        logic [7:0] m;
        m = 8'hA5 ^ {4'h0, t};
        return {m, v ^ m};
    endfunction

    function automatic logic [7:0] rxor(input logic [15:0] d);
        return d[7:0] ^ d[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External sbox with LAT edges of latency
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= sbox_f(bus.SboxInxDO);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.SboxOutxDI = pipe[LAT-1];

    // Reference model: queue of accepted bytes, each due LAT+1 edges after accept
    typedef struct {
        int          due;
        logic        src;
        logic [3:0]  tag;
        logic [15:0] din;
    } ent_t;
    ent_t        mq[$];
    ent_t        e;
    logic        m_ptr;
    logic [15:0] e_sin, e_rd;
    logic [3:0]  e_rt;
    logic [7:0]  e_rx;
    logic        e_va, e_vb, e_busy;
    logic        ga, gb, ok;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_ptr = 1'b0; e_sin = '0; e_rd = '0; e_rt = '0; e_rx = '0;
            e_va = 1'b0; e_vb = 1'b0; e_busy = 1'b0;
            chk("rst_sbox_in", 32'(bus.SboxInxDO), 0);
            chk("rst_rsp_data", 32'(bus.RspDataxDO), 0);
            chk("rst_rsp_tag", 32'(bus.RspTagxDO), 0);
            chk("rst_rsp_valid", 32'({bus.RspAValidxSO, bus.RspBValidxSO}), 0);
            chk("rst_busy", 32'(bus.BusyxSO), 0);
        end else begin
            chk("sbox_in", 32'(bus.SboxInxDO), 32'(e_sin));
            chk("rsp_a_valid", 32'(bus.RspAValidxSO), 32'(e_va));
            chk("rsp_b_valid", 32'(bus.RspBValidxSO), 32'(e_vb));
            chk("rsp_data", 32'(bus.RspDataxDO), 32'(e_rd));
            chk("rsp_tag", 32'(bus.RspTagxDO), 32'(e_rt));
            chk("busy", 32'(bus.BusyxSO), 32'(e_busy));
            if (e_va || e_vb) chk("recombined", 32'(rxor(bus.RspDataxDO)), 32'(e_rx));

            ga = bus.ReqAValidxSI && (!bus.ReqBValidxSI || m_ptr == 1'b0);
            gb = bus.ReqBValidxSI && (!bus.ReqAValidxSI || m_ptr == 1'b1);
            ok = bus.RndValidxSI && !bus.ClearxSI;
            chk("ready_a", 32'(bus.ReqAReadyxSO), 32'(ga && ok));
            chk("ready_b", 32'(bus.ReqBReadyxSO), 32'(gb && ok));
            chk("rnd_req", 32'(bus.RndReqxSO), 32'((ga || gb) && ok));
            chk("one_ready", 32'(bus.ReqAReadyxSO && bus.ReqBReadyxSO), 0);

            e_va = 1'b0;
            e_vb = 1'b0;
            if (mq.size() > 0 && mq[0].due == cyc + 1) begin
                e    = mq.pop_front();
                e_va = !e.src;
                e_vb = e.src;
                e_rd = sbox_f(e.din);
                e_rt = e.tag;
                e_rx = sbox_tab[rxor(e.din)];
            end
            if (bus.ClearxSI) mq.delete();
            if (ga && ok) begin
                mq.push_back('{cyc + 2 + LAT, 1'b0, bus.ReqATagxDI, bus.ReqADataxDI});
                e_sin = bus.ReqADataxDI;
                m_ptr = 1'b1;
            end else if (gb && ok) begin
                mq.push_back('{cyc + 2 + LAT, 1'b1, bus.ReqBTagxDI, bus.ReqBDataxDI});
                e_sin = bus.ReqBDataxDI;
                m_ptr = 1'b0;
            end
            e_busy = (mq.size() > 0);
        end
    end

    task automatic idle();
        bus.ReqAValidxSI = 1'b0; bus.ReqBValidxSI = 1'b0;
        bus.ReqADataxDI = '0; bus.ReqBDataxDI = '0;
        bus.ReqATagxDI = '0; bus.ReqBTagxDI = '0;
        bus.ClearxSI = 1'b0; bus.RndValidxSI = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic        ra, rb;
    int          ta, tb, nrsp, nreq;
    logic        g_src [16];
    logic [3:0]  g_tag [16];
    logic [7:0]  g_x   [16];
    int          g_cyc [16];
    logic [15:0] sin [4];

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single A request of value 0x00
        bus.ReqAValidxSI = 1'b1; bus.ReqADataxDI = 16'h5A5A; bus.ReqATagxDI = 4'd3;
        bus.RndValidxSI = 1'b1;
        #2 chk("t1_ready_a", 32'(bus.ReqAReadyxSO), 1);
        @(posedge clk); #1;
        bus.ReqAValidxSI = 1'b0;
        chk("t1_busy_start", 32'(bus.BusyxSO), 1);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(posedge clk); #1;
            if (i <= LAT) begin
                chk("t1_busy_flight", 32'(bus.BusyxSO), 1);
                chk("t1_no_rsp_yet", 32'(bus.RspAValidxSO), 0);
            end else begin
                chk("t1_rsp_a", 32'(bus.RspAValidxSO), 1);
                chk("t1_busy_done", 32'(bus.BusyxSO), 0);
                chk("t1_value", 32'(rxor(bus.RspDataxDO)), 'h63);
                chk("t1_tag", 32'(bus.RspTagxDO), 3);
            end
        end
        @(posedge clk); #1;
        chk("t1_pulse_end", 32'(bus.RspAValidxSO), 0);

        // Both ports every cycle: alternating grants A first after reset
        pulse_reset();
        ta = 0; tb = 8; nrsp = 0;
        bus.RndValidxSI = 1'b1;
        bus.ReqAValidxSI = 1'b1; bus.ReqADataxDI = mk(8'h53, 4'(ta)); bus.ReqATagxDI = 4'(ta);
        bus.ReqBValidxSI = 1'b1; bus.ReqBDataxDI = mk(8'h01, 4'(tb)); bus.ReqBTagxDI = 4'(tb);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    ra = bus.ReqAReadyxSO; rb = bus.ReqBReadyxSO;
                    if (i == 0) chk("t2_first_grant_a", 32'(ra), 1);
                    @(posedge clk); #1;
                    if (ra) begin ta++; bus.ReqADataxDI = mk(8'h53, 4'(ta)); bus.ReqATagxDI = 4'(ta); end
                    if (rb) begin tb++; bus.ReqBDataxDI = mk(8'h01, 4'(tb)); bus.ReqBTagxDI = 4'(tb); end
                end
                bus.ReqAValidxSI = 1'b0; bus.ReqBValidxSI = 1'b0;
            end
            begin
                for (int c = 0; c < LAT + 14; c++) begin
                    @(posedge clk); #1;
                    if ((bus.RspAValidxSO || bus.RspBValidxSO) && nrsp < 16) begin
                        g_src[nrsp] = bus.RspBValidxSO;
                        g_tag[nrsp] = bus.RspTagxDO;
                        g_x[nrsp]   = rxor(bus.RspDataxDO);
                        g_cyc[nrsp] = c;
                        nrsp++;
                    end
                end
            end
        join
        chk("t2_a_accepts", 32'(ta), 4);
        chk("t2_b_accepts", 32'(tb), 12);
        chk("t2_rsp_count", 32'(nrsp), 8);
        for (int k = 0; k < nrsp && k < 8; k++) begin
            chk("t2_src", 32'(g_src[k]), 32'(k % 2));
            chk("t2_tag", 32'(g_tag[k]), (k % 2 == 1) ? 32'(8 + k / 2) : 32'(k / 2));
            chk("t2_value", 32'(g_x[k]), (k % 2 == 1) ? 'h7C : 'hED);
            if (k > 0) chk("t2_back_to_back", 32'(g_cyc[k] - g_cyc[k-1]), 1);
        end

        // B only with RndValid toggling 1,0,1,0
        nreq = 0;
        bus.ReqBValidxSI = 1'b1; bus.ReqBDataxDI = mk(8'h10, 4'd1); bus.ReqBTagxDI = 4'd1;
        for (int i = 0; i < 4; i++) begin
            bus.RndValidxSI = (i % 2 == 0);
            @(negedge clk);
            if (bus.RndReqxSO) nreq++;
            rb = bus.ReqBReadyxSO;
            @(posedge clk); #1;
            sin[i] = bus.SboxInxDO;
            if (rb && bus.ReqBTagxDI == 4'd1) begin
                bus.ReqBDataxDI = mk(8'h20, 4'd2); bus.ReqBTagxDI = 4'd2;
            end else if (rb) begin
                bus.ReqBValidxSI = 1'b0;
            end
        end
        chk("t3_rnd_pulses", 32'(nreq), 2);
        chk("t3_sin0", 32'(sin[0]), 32'(mk(8'h10, 4'd1)));
        chk("t3_sin1_held", 32'(sin[1]), 32'(mk(8'h10, 4'd1)));
        chk("t3_sin2", 32'(sin[2]), 32'(mk(8'h20, 4'd2)));
        chk("t3_sin3_held", 32'(sin[3]), 32'(mk(8'h20, 4'd2)));
        bus.ReqBValidxSI = 1'b0;
        bus.RndValidxSI = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Three bytes in flight, then a flush
        bus.ReqAValidxSI = 1'b1;
        for (int i = 5; i < 8; i++) begin
            bus.ReqADataxDI = mk(8'(i * 17), 4'(i)); bus.ReqATagxDI = 4'(i);
            @(posedge clk); #1;
        end
        bus.ReqADataxDI = mk(8'h99, 4'd8); bus.ReqATagxDI = 4'd8;
        bus.ClearxSI = 1'b1;
        #2 chk("t4_no_accept_on_clear", 32'(bus.ReqAReadyxSO), 0);
        @(posedge clk); #1;
        bus.ClearxSI = 1'b0;
        chk("t4_busy_cleared", 32'(bus.BusyxSO), 0);
        nrsp = 0; ta = 0;
        for (int c = 0; c < LAT + 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) bus.ReqAValidxSI = 1'b0;
            if (bus.RspAValidxSO || bus.RspBValidxSO) begin
                nrsp++;
                ta = int'(bus.RspTagxDO);
            end
        end
        chk("t4_rsp_count", 32'(nrsp), 1);
        chk("t4_rsp_tag", 32'(ta), 8);

        // Asynchronous reset mid-flight
        bus.ReqAValidxSI = 1'b1; bus.ReqADataxDI = mk(8'h42, 4'd9); bus.ReqATagxDI = 4'd9;
        @(posedge clk); #1;
        bus.ReqADataxDI = mk(8'h43, 4'd10); bus.ReqATagxDI = 4'd10;
        @(posedge clk); #1;
        bus.ReqAValidxSI = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_sbox_in_zero", 32'(bus.SboxInxDO), 0);
        chk("t5_rsp_data_zero", 32'(bus.RspDataxDO), 0);
        chk("t5_busy_zero", 32'(bus.BusyxSO), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ReqAValidxSI = 1'b1; bus.ReqADataxDI = mk(8'hC0, 4'd11); bus.ReqATagxDI = 4'd11;
        bus.ReqBValidxSI = 1'b1; bus.ReqBDataxDI = mk(8'hC1, 4'd12); bus.ReqBTagxDI = 4'd12;
        #2;
        chk("t5_post_reset_a", 32'(bus.ReqAReadyxSO), 1);
        chk("t5_post_reset_b", 32'(bus.ReqBReadyxSO), 0);
        @(posedge clk); #1;
        bus.ReqAValidxSI = 1'b0; bus.ReqBValidxSI = 1'b0;
        repeat (LAT + 6) @(posedge clk);
        #1;

        // Random traffic on both ports
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ra = bus.ReqAReadyxSO; rb = bus.ReqBReadyxSO;
            @(posedge clk); #1;
            if (!bus.ReqAValidxSI || ra) begin
                bus.ReqAValidxSI = ($urandom_range(0, 2) != 0);
                bus.ReqADataxDI  = 16'($urandom);
                bus.ReqATagxDI   = 4'($urandom);
            end
            if (!bus.ReqBValidxSI || rb) begin
                bus.ReqBValidxSI = ($urandom_range(0, 2) != 0);
                bus.ReqBDataxDI  = 16'($urandom);
                bus.ReqBTagxDI   = 4'($urandom);
            end
            bus.RndValidxSI = ($urandom_range(0, 3) != 0);
            bus.ClearxSI    = ($urandom_range(0, 49) == 0);
        end
        idle();
        repeat (LAT + 4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
